// File: rtl/mfft_pkg.sv
// Shared types and helpers for the radix-2 merge-stage scheduler.
// Holds the FSM state enum, the NFFT size helper and the address bit-reverse helper.
package mfft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SRC,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  function automatic int unsigned nfft(input int unsigned size_buffer);
    return 32'd1 << size_buffer;
  endfunction

  // Reverse the low 'width' bits of addr; the upper bits are returned as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] addr, input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) r[5'(i)] = addr[5'(width - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/mfft_delay_line.sv
// 1-bit shift register of parameterised depth with synchronous clear.
// Used to align the even-sample pops and the write strobes with the datapath latency.
module mfft_delay_line #(
  parameter int unsigned DEPTH = 1
) (
  input  logic i_clk,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge i_clk) begin
        if (clr_i) sr_q <= '0;
        else       sr_q <= d_i;
      end
    end else begin : g_many
      always_ff @(posedge i_clk) begin
        if (clr_i) sr_q <= '0;
        else       sr_q <= {sr_q[DEPTH-2:0], d_i};
      end
    end
  endgenerate

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/mfft_merge_scheduler.sv
// Frame controller for the even/odd radix-2 merge stage: source handshake, odd/even
// streaming, output-RAM write addressing and timeouts. MFFT_MERGE_BITREV_EN selects bit-reversed addresses.
module mfft_merge_scheduler
  import mfft_pkg::*;
#(
  parameter int unsigned SIZE_BUFFER  = 4,
  parameter int unsigned MULT_LATENCY = 3,
  parameter int unsigned SUMM_LATENCY = 1,
  parameter int unsigned MAX_SKEW     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_even_ready,
  input  logic                   i_odd_ready,
  output logic                   o_odd_rd,
  output logic                   o_even_rd,
  output logic                   o_mult_en,
  output logic [SIZE_BUFFER-1:0] o_phi,
  input  logic                   i_mult_valid,
  output logic                   o_wr_en,
  output logic [SIZE_BUFFER-1:0] o_wr_addr_lo,
  output logic [SIZE_BUFFER-1:0] o_wr_addr_hi,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err_timeout
);

  localparam int unsigned HALF     = nfft(SIZE_BUFFER) / 2;
  localparam int unsigned KW       = SIZE_BUFFER - 1;
  localparam int unsigned SKW_W    = $clog2(MAX_SKEW) + 1;
  localparam int unsigned WD_LIMIT = MULT_LATENCY + SUMM_LATENCY + MAX_SKEW;
  localparam int unsigned WD_W     = $clog2(WD_LIMIT) + 1;
  localparam logic [KW-1:0]    K_LAST   = KW'(HALF - 1);
  localparam logic [SKW_W-1:0] SKEW_MAX = SKW_W'(MAX_SKEW);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WD_LIMIT - 1);

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [KW-1:0]    w_q, w_d;
  logic             w_full_q, w_full_d;
  logic [SKW_W-1:0] skew_q, skew_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic even_dly, wr_dly;
  logic active_c, wr_fire_c, both_rdy_c, any_rdy_c, skew_to_c, wd_to_c;
  logic [SIZE_BUFFER-1:0] lo_nat_c, hi_nat_c;

  assign active_c   = (state_q == STREAM) || (state_q == DRAIN);
  assign wr_fire_c  = wr_dly & active_c;
  assign both_rdy_c = i_even_ready & i_odd_ready;
  assign any_rdy_c  = i_even_ready | i_odd_ready;
  assign skew_to_c  = (state_q == WAIT_SRC) && !both_rdy_c && (skew_q == SKEW_MAX);
  assign wd_to_c    = (state_q == DRAIN) && !w_full_q && !wr_fire_c && (wd_q == WD_LAST);
  assign lo_nat_c   = {1'b0, w_q};
  assign hi_nat_c   = {1'b1, w_q};

  // Valids outside an active frame never enter the write pipe.
  mfft_delay_line #(.DEPTH(MULT_LATENCY)) u_even_dly (
    .i_clk (i_clk),
    .clr_i (i_reset),
    .d_i   (o_mult_en),
    .q_o   (even_dly)
  );

  mfft_delay_line #(.DEPTH(SUMM_LATENCY)) u_wr_dly (
    .i_clk (i_clk),
    .clr_i (i_reset),
    .d_i   (i_mult_valid & active_c),
    .q_o   (wr_dly)
  );

  // State and counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      w_q      <= '0;
      w_full_q <= 1'b0;
      skew_q   <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      w_q      <= w_d;
      w_full_q <= w_full_d;
      skew_q   <= skew_d;
      wd_q     <= wd_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    w_d      = w_q;
    w_full_d = w_full_q;
    skew_d   = skew_q;
    wd_d     = wd_q;

    // Write counter and no-write watchdog run across STREAM and DRAIN.
    if (active_c) begin
      if (wr_fire_c) begin
        w_d  = w_q + 1'b1;
        wd_d = '0;
        if (w_q == K_LAST) w_full_d = 1'b1;
      end else if (wd_q != WD_LAST) begin
        wd_d = wd_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        k_d      = '0;
        w_d      = '0;
        w_full_d = 1'b0;
        skew_d   = '0;
        wd_d     = '0;
        if (i_start) state_d = WAIT_SRC;
      end
      WAIT_SRC: begin
        if (both_rdy_c)                      state_d = STREAM;
        else if (skew_to_c)                  state_d = IDLE;
        else if (skew_q != '0 || any_rdy_c)  skew_d  = skew_q + 1'b1;
      end
      STREAM: begin
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (w_full_q || (wr_fire_c && w_q == K_LAST)) state_d = DONE;
        else if (wd_to_c)                              state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state and counters.
  always_comb begin
    o_odd_rd      = 1'b0;
    o_mult_en     = 1'b0;
    o_phi         = '0;
    o_wr_en       = 1'b0;
    o_wr_addr_lo  = '0;
    o_wr_addr_hi  = '0;
    o_even_rd     = even_dly;
    o_busy        = (state_q != IDLE);
    o_done        = (state_q == DONE);
    o_err_timeout = skew_to_c | wd_to_c;

    if (state_q == STREAM) begin
      o_odd_rd  = 1'b1;
      o_mult_en = 1'b1;
      o_phi     = {1'b0, k_q};
    end

    if (wr_fire_c) begin
      o_wr_en = 1'b1;
`ifdef MFFT_MERGE_BITREV_EN
      o_wr_addr_lo = SIZE_BUFFER'(bitrev(32'(lo_nat_c), SIZE_BUFFER));
      o_wr_addr_hi = SIZE_BUFFER'(bitrev(32'(hi_nat_c), SIZE_BUFFER));
`else
      o_wr_addr_lo = lo_nat_c;
      o_wr_addr_hi = hi_nat_c;
`endif
    end
  end

endmodule

// File: tb/tb_mfft_merge_scheduler.sv
// Directed cycle-by-cycle bench for mfft_merge_scheduler (NFFT=8); the multiplier is
// modelled as a 3-cycle return of o_mult_en. Honours MFFT_MERGE_BITREV_EN for address expectations.
module tb_mfft_merge_scheduler;

  logic       clk;
  logic       i_reset;
  logic       i_start;
  logic       i_even_ready;
  logic       i_odd_ready;
  logic       o_odd_rd;
  logic       o_even_rd;
  logic       o_mult_en;
  logic [2:0] o_phi;
  logic       i_mult_valid;
  logic       o_wr_en;
  logic [2:0] o_wr_addr_lo;
  logic [2:0] o_wr_addr_hi;
  logic       o_busy;
  logic       o_done;
  logic       o_err_timeout;

  int checks = 0;
  int errors = 0;

  logic [2:0] mv_pipe = '0;
  int         mv_sent = 0;
  int         mv_limit = 99;

  mfft_merge_scheduler #(
    .SIZE_BUFFER  (3),
    .MULT_LATENCY (3),
    .SUMM_LATENCY (1),
    .MAX_SKEW     (8)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_even_ready  (i_even_ready),
    .i_odd_ready   (i_odd_ready),
    .o_odd_rd      (o_odd_rd),
    .o_even_rd     (o_even_rd),
    .o_mult_en     (o_mult_en),
    .o_phi         (o_phi),
    .i_mult_valid  (i_mult_valid),
    .o_wr_en       (o_wr_en),
    .o_wr_addr_lo  (o_wr_addr_lo),
    .o_wr_addr_hi  (o_wr_addr_hi),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err_timeout (o_err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: result valid 3 cycles after enable, optionally capped per frame.
  always @(posedge clk) begin
    mv_pipe <= {mv_pipe[1:0], o_mult_en};
    if (!o_busy)           mv_sent <= 0;
    else if (i_mult_valid) mv_sent <= mv_sent + 1;
  end
  assign i_mult_valid = mv_pipe[2] && (mv_sent < mv_limit);

  logic [15:0] act_v;
  assign act_v = {o_odd_rd, o_even_rd, o_mult_en, o_phi, o_wr_en,
                  o_wr_addr_lo, o_wr_addr_hi, o_busy, o_done, o_err_timeout};

  function automatic logic [15:0] exp_v(input bit odd, input bit even, input bit mult,
                                        input int phi, input bit wr, input int w,
                                        input bit busy, input bit done, input bit err);
    logic [2:0] lo, hi;
    lo = 3'd0;
    hi = 3'd0;
    if (wr) begin
`ifdef MFFT_MERGE_BITREV_EN
      case (w)
        0: begin lo = 3'd0; hi = 3'd1; end
        1: begin lo = 3'd4; hi = 3'd5; end
        2: begin lo = 3'd2; hi = 3'd3; end
        default: begin lo = 3'd6; hi = 3'd7; end
      endcase
`else
      lo = 3'(w);
      hi = 3'(w + 4);
`endif
    end
    return {odd, even, mult, 3'(phi), wr, lo, hi, busy, done, err};
  endfunction

  task automatic drive(input logic st, input logic er, input logic od);
    @(posedge clk);
    #1;
    i_reset      = 1'b0;
    i_start      = st;
    i_even_ready = er;
    i_odd_ready  = od;
    #1;
  endtask

  task automatic chk(input string tag, input int c, input logic [15:0] e);
    checks++;
    assert (act_v === e) else begin
      errors++;
      $error("FAIL %s c%0d: observed %h expected %h", tag, c, act_v, e);
    end
  endtask

  // One frame: start at c0, even ready at c2, odd ready d cycles later; optional stray starts.
  task automatic run_frame(input string tag, input int d, input bit spur);
    int last;
    last = 12 + d + (spur ? 4 : 0);
    for (int c = 0; c <= last; c++) begin
      int cc;
      bit st, wr;
      cc = c - d;
      st = (c == 0) || (spur && (c == 4 + d || c == 8 + d));
      wr = (cc >= 7 && cc <= 10);
      drive(st, c >= 2 && c <= 10 + d, c >= 2 + d && c <= 10 + d);
      chk(tag, c, exp_v(cc >= 3 && cc <= 6, cc >= 6 && cc <= 9, cc >= 3 && cc <= 6,
                        (cc >= 3 && cc <= 6) ? cc - 3 : 0, wr, wr ? cc - 7 : 0,
                        c >= 1 && c <= 11 + d, c == 11 + d, 1'b0));
    end
  endtask

  initial begin
    i_reset      = 1'b1;
    i_start      = 1'b0;
    i_even_ready = 1'b0;
    i_odd_ready  = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state, then ready flags with no start leave the block idle.
    drive(1'b0, 1'b0, 1'b0);
    chk("reset", 0, 16'h0000);
    drive(1'b0, 1'b1, 1'b1);
    chk("idle_ready_ignored", 0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0);
    chk("idle_ready_ignored", 1, 16'h0000);

    run_frame("nominal", 0, 1'b0);
    run_frame("skew_ok", 5, 1'b0);

    // Skew failure: a few idle waits, even ready at c5, odd never.
    for (int c = 0; c <= 14; c++) begin
      drive(c == 0, c >= 5 && c <= 13, 1'b0);
      chk("skew_fail", c, exp_v(0, 0, 0, 0, 0, 0, c >= 1 && c <= 13, 0, c == 13));
    end

    // Reset in the cycle showing phi=2: everything clears the next cycle.
    for (int c = 0; c <= 5; c++) begin
      drive(c == 0, c >= 2, c >= 2);
      chk("pre_reset", c, exp_v(c >= 3, 0, c >= 3, (c >= 3) ? c - 3 : 0, 0, 0, c >= 1, 0, 0));
    end
    i_reset = 1'b1;
    for (int c = 6; c <= 10; c++) begin
      drive(1'b0, 1'b0, 1'b0);
      chk("post_reset", c, 16'h0000);
    end
    run_frame("after_reset", 0, 1'b0);

    run_frame("start_ignored", 0, 1'b1);

    // Watchdog: only two multiplier results come back.
    mv_limit = 2;
    for (int c = 0; c <= 21; c++) begin
      bit wr;
      wr = (c == 7 || c == 8);
      drive(c == 0, c >= 2 && c <= 10, c >= 2 && c <= 10);
      chk("watchdog", c, exp_v(c >= 3 && c <= 6, c >= 6 && c <= 9, c >= 3 && c <= 6,
                               (c >= 3 && c <= 6) ? c - 3 : 0, wr, wr ? c - 7 : 0,
                               c >= 1 && c <= 20, 0, c == 20));
    end
    mv_limit = 99;

    run_frame("recover", 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mfft_merge_scheduler.md
Name: mfft_merge_scheduler

Overview:
- Frame-level controller for the even/odd radix-2 merge stage.
- Waits for both half-size sub-FFTs to report a complete half-frame, then streams NFFT/2 odd samples into the twiddle multiplier with index phi = k.
- Pops even samples aligned to the multiplier output.
- Turns multiplier-valid into output-RAM writes at addresses k and k+NFFT/2, and reports frame done or timeout errors.

Parameters:
- SIZE_BUFFER, 4, log2(NFFT); NFFT = 1<<SIZE_BUFFER.
- MULT_LATENCY, 3, cycles from mult enable to multiplier output valid.
- SUMM_LATENCY, 1, cycles from multiplier output to registered adder output.
- MAX_SKEW, 8, max cycles allowed between the first and second ready flag.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  arm for one frame; sampled only in IDLE.
- i_even_ready  in  1  even sub-FFT half-frame available (level).
- i_odd_ready  in  1  odd sub-FFT half-frame available (level).
- o_odd_rd  out  1  pop one odd sample.
- o_even_rd  out  1  pop one even sample.
- o_mult_en  out  1  multiplier enable.
- o_phi  out  SIZE_BUFFER  twiddle index.
- i_mult_valid  in  1  multiplier output valid.
- o_wr_en  out  1  write both butterfly results.
- o_wr_addr_lo  out  SIZE_BUFFER  address for the k result.
- o_wr_addr_hi  out  SIZE_BUFFER  address for the k+NFFT/2 result.
- o_busy  out  1  high in any state except IDLE.
- o_done  out  1  one-cycle frame-complete pulse.
- o_err_timeout  out  1  one-cycle error pulse.

Behaviour:
- Reset: i_reset synchronous, active-high, clock i_clk. All outputs 0, state IDLE, all counters and delay lines cleared. Reset mid-frame aborts immediately; there is no partial done.
- States: IDLE, WAIT_SRC, STREAM, DRAIN, DONE.
- IDLE:
  - i_start=1 -> WAIT_SRC next cycle.
  - Ready flags are ignored in IDLE.
- WAIT_SRC:
  - Skew counter starts on the first cycle either ready is high.
  - Both ready in the same sampled cycle -> STREAM next cycle.
  - Counter reaches MAX_SKEW with only one ready -> o_err_timeout pulse, then IDLE.
  - Neither ready -> wait indefinitely.
- STREAM:
  - Lasts exactly NFFT/2 cycles.
  - o_odd_rd = o_mult_en = 1; o_phi = 0..NFFT/2-1, incrementing each cycle.
  - Last cycle -> DRAIN.
- Even alignment: o_even_rd = o_mult_en delayed by MULT_LATENCY cycles (shift register). It keeps running through DRAIN.
- Write path:
  - o_wr_en = i_mult_valid delayed by SUMM_LATENCY cycles.
  - Write counter w advances on each o_wr_en.
  - o_wr_addr_lo = w; o_wr_addr_hi = w + NFFT/2 (top bit set).
  - Writes may start during STREAM.
- DRAIN:
  - On the write that makes w = NFFT/2 -> DONE.
  - Watchdog: no o_wr_en for MULT_LATENCY+SUMM_LATENCY+MAX_SKEW consecutive cycles -> o_err_timeout pulse, then IDLE.
- DONE: o_done=1 for one cycle -> IDLE. o_busy is still 1 in DONE.
- i_mult_valid while w has already reached NFFT/2, or while in IDLE/WAIT_SRC: ignored, no write.
- i_start outside IDLE: ignored.
- Counter widths: SIZE_BUFFER-1 bits for k and w, with wrap prevented by the state machine. Skew and watchdog counters are sized by $clog2 of their limit + 1.

Optional Feature:
- Macro MFFT_MERGE_BITREV_EN.
- Defined: o_wr_addr_lo/hi are the SIZE_BUFFER-bit bit-reverse of the natural addresses, for a bit-reversed output buffer.
- Undefined: natural order as above.
- No timing difference in either case.

Decomposition:
- Package mfft_pkg holds:
  - state enum (IDLE/WAIT_SRC/STREAM/DRAIN/DONE);
  - function nfft(size_buffer);
  - function bitrev(addr, width).
- One sub-module, mfft_delay_line (parameterised depth, 1-bit shift register with synchronous clear), instantiated twice: even-read alignment and write-valid alignment.

Test Plan (SIZE_BUFFER=3, MULT_LATENCY=3, SUMM_LATENCY=1, MAX_SKEW=8; bench returns i_mult_valid 3 cycles after o_mult_en):
- Nominal: i_start at c0; both ready at c2 -> STREAM c3..c6.
  - o_phi 0,1,2,3; o_even_rd c6..c9.
  - o_wr_en c7..c10; lo 0..3, hi 4..7.
  - o_done pulse at c11; o_busy low at c12.
- Skew ok / skew fail:
  - even ready at t, odd at t+5 -> normal frame.
  - odd never arrives -> o_err_timeout pulse after 8 cycles, no o_odd_rd, back to IDLE.
- Reset mid-STREAM after o_phi=2 -> next cycle all outputs 0, no o_done. A new i_start then runs a clean nominal frame.
- i_start pulsed during STREAM and DRAIN -> ignored: exactly one o_done, no second frame.
- Bench stops i_mult_valid after 2 results -> watchdog expires 12 cycles after the last o_wr_en, o_err_timeout pulse, IDLE.
- With MFFT_MERGE_BITREV_EN -> lo addresses 0,4,2,6; hi addresses 1,5,3,7; same cycle timing as the nominal case.
